// File: rtl/edge_frame_ctrl.sv
// Frame sequencer for the edge pixel pipeline: walks x/y over accepted beats, then drains the line buffers.
// Optional frame statistics (in_beats/out_beats) are built only when EDGE_FRAME_STATS_EN is defined.
module edge_frame_ctrl #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PPB         = 8,
    parameter int FLUSH_BEATS = 3 * WIDTH / PPB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        pipe_valid,
    output logic        pipe_flush,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    input  logic        sink_valid,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] in_beats,
    output logic [31:0] out_beats
);

    localparam int FC_W = (FLUSH_BEATS > 1) ? $clog2(FLUSH_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     x_nxt, y_nxt;
    logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [16:0]     x_sum;
    logic            line_end;
    logic            accept;

    assign x_sum      = {1'b0, x} + 17'(PPB);
    assign line_end   = (x_sum >= 17'(WIDTH));
    assign src_ready  = (state == RUN);
    assign accept     = src_valid && src_ready;
    assign sof        = accept && (x == 16'd0) && (y == 16'd0);
    assign eol        = accept && line_end;
    assign eof        = eol && (y == 16'(HEIGHT - 1));
    assign pipe_valid = accept || (state == FLUSH);
    assign pipe_flush = (state == FLUSH);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // abort wins over every other transition, including an eof beat or the last flush cycle
    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        flush_cnt_nxt = flush_cnt;
        if (abort) begin
            state_nxt     = IDLE;
            x_nxt         = '0;
            y_nxt         = '0;
            flush_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        x_nxt     = '0;
                        y_nxt     = '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (line_end) begin
                            x_nxt = '0;
                            y_nxt = y + 16'd1;
                        end else begin
                            x_nxt = x_sum[15:0];
                        end
                        if (eof) begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = '0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FC_W'(FLUSH_BEATS - 1)) begin
                        state_nxt     = DONE;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt + 1'b1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef EDGE_FRAME_STATS_EN
    logic [31:0] in_cnt, out_cnt, in_lat, out_lat;

    // counters restart with each frame; latched copies only move on a clean DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            in_lat  <= '0;
            out_lat <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (busy) begin
                if (accept)     in_cnt  <= in_cnt + 32'd1;
                if (sink_valid) out_cnt <= out_cnt + 32'd1;
            end
            if (state == DONE && !abort) begin
                in_lat  <= in_cnt;
                out_lat <= out_cnt;
            end
        end
    end

    assign in_beats  = in_lat;
    assign out_beats = out_lat;
`else
    logic unused_sink_valid;
    assign unused_sink_valid = sink_valid;
    assign in_beats          = '0;
    assign out_beats         = '0;
`endif

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Directed bench for edge_frame_ctrl: a beat-index model checked every cycle plus literal frame expectations.
module tb_edge_frame_ctrl;

    localparam int WIDTH       = 32;
    localparam int HEIGHT      = 4;
    localparam int PPB         = 8;
    localparam int FLUSH_BEATS = 12;
    localparam int BPL         = WIDTH / PPB;
    localparam int TOTAL       = BPL * HEIGHT;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, src_valid, sink_valid;
    logic        src_ready, pipe_valid, pipe_flush, sof, eol, eof, busy, frame_done;
    logic [15:0] x, y;
    logic [31:0] in_beats, out_beats;

    always #5 clk = ~clk;

    edge_frame_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PPB(PPB), .FLUSH_BEATS(FLUSH_BEATS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_valid(src_valid), .src_ready(src_ready), .pipe_valid(pipe_valid), .pipe_flush(pipe_flush),
        .x(x), .y(y), .sof(sof), .eol(eol), .eof(eof), .sink_valid(sink_valid), .busy(busy),
        .frame_done(frame_done), .in_beats(in_beats), .out_beats(out_beats)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: phase 0 idle, 1 run, 2 flush, 3 done; m_n = beats accepted this frame
    int          m_phase, m_n, m_fc, m_sin, m_sout;
    logic [31:0] m_in_lat, m_out_lat;
    bit          last_pv;

    int          mon_acc, mon_fl, mon_last_fl, mon_done_cyc, done_total;
    logic [31:0] mon_sof, mon_eol, mon_eof;
    bit          mon_seen;
    int          d0;
    logic [31:0] exp_in16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_fc = 0; m_sin = 0; m_sout = 0;
        m_in_lat = '0; m_out_lat = '0;
    endtask

    task automatic compare();
        logic        e_acc;
        logic [7:0]  e_ctrl;
        logic [31:0] e_in, e_out;
        e_acc  = (m_phase == 1) && src_valid;
        e_ctrl = {m_phase == 1, e_acc || m_phase == 2, m_phase == 2, m_phase != 0, m_phase == 3,
                  e_acc && m_n == 0, e_acc && (m_n % BPL == BPL - 1), e_acc && (m_n == TOTAL - 1)};
        check("ctrl", {src_ready, pipe_valid, pipe_flush, busy, frame_done, sof, eol, eof}, e_ctrl);
        check("xy", {x, y}, {16'((m_n % BPL) * PPB), 16'(m_n / BPL)});
`ifdef EDGE_FRAME_STATS_EN
        e_in = m_in_lat; e_out = m_out_lat;
`else
        e_in = '0; e_out = '0;
`endif
        check("stats", {in_beats, out_beats}, {e_in, e_out});
        if (rst_n && !busy && start) begin
            mon_acc = 0; mon_fl = 0; mon_last_fl = 0; mon_done_cyc = 0; mon_seen = 0;
            mon_sof = '0; mon_eol = '0; mon_eof = '0;
        end
        if (src_valid && src_ready) begin
            if (mon_acc < 32) begin
                if (sof) mon_sof |= (32'd1 << mon_acc);
                if (eol) mon_eol |= (32'd1 << mon_acc);
                if (eof) mon_eof |= (32'd1 << mon_acc);
            end
            mon_acc++;
        end
        if (pipe_flush) begin mon_fl++; mon_last_fl = cyc; end
        if (frame_done) begin done_total++; mon_done_cyc = cyc; mon_seen = 1; end
        last_pv = pipe_valid;
    endtask

    task automatic advance();
        int acc;
        if (!rst_n) return;
        acc = (m_phase == 1 && src_valid) ? 1 : 0;
        if (m_phase == 3 && !abort) begin m_in_lat = 32'(m_sin); m_out_lat = 32'(m_sout); end
        if (m_phase != 0) begin m_sin += acc; m_sout += sink_valid ? 1 : 0; end
        if (abort) begin
            m_phase = 0; m_n = 0; m_fc = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_n = 0; m_sin = 0; m_sout = 0; end
                1: if (acc == 1) begin
                       m_n++;
                       if (m_n == TOTAL) begin m_phase = 2; m_fc = 0; end
                   end
                2: begin m_fc++; if (m_fc == FLUSH_BEATS) m_phase = 3; end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc++;
        advance();
        #1;
        sink_valid = last_pv;
    endtask

    task automatic wait_done(input bit toggle, input int budget);
        for (int i = 0; i < budget && !mon_seen; i++) begin
            if (toggle) src_valid = ~src_valid;
            step();
        end
        if (!mon_seen) begin
            n_tests++; n_fail++;
            $display("FAIL frame_done_timeout cycle %0d: got none expected pulse within %0d cycles", cyc, budget);
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_acc"}, 64'(mon_acc), 64'd16);
        check({tag, "_sof"}, 64'(mon_sof), 64'h1);
        check({tag, "_eol"}, 64'(mon_eol), 64'h8888);
        check({tag, "_eof"}, 64'(mon_eof), 64'h8000);
        check({tag, "_flush"}, 64'(mon_fl), 64'd12);
        check({tag, "_done_gap"}, 64'(mon_done_cyc - mon_last_fl), 64'd1);
    endtask

    initial begin
`ifdef EDGE_FRAME_STATS_EN
        exp_in16 = 32'd16;
`else
        exp_in16 = 32'd0;
`endif
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; sink_valid = 1'b0;
        done_total = 0; mon_seen = 0; mon_acc = 0; mon_fl = 0; mon_last_fl = 0; mon_done_cyc = 0;
        mon_sof = '0; mon_eol = '0; mon_eof = '0; last_pv = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_xy", {x, y}, 64'd0);
        check("rst_in_beats", 64'(in_beats), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // continuous source
        start = 1'b1; src_valid = 1'b1;
        step();
        start = 1'b0;
        wait_done(1'b0, 100);
        check_frame("cont");
        check("cont_in_beats", 64'(in_beats), 64'(exp_in16));
        src_valid = 1'b0;
        repeat (3) step();
        check("cont_idle_busy", 64'(busy), 64'd0);

        // source valid every other cycle
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1'b1, 200);
        check("gap_acc", 64'(mon_acc), 64'd16);
        check("gap_eol", 64'(mon_eol), 64'h8888);
        src_valid = 1'b0;
        repeat (2) step();

        // abort on beat 6
        start = 1'b1; src_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        abort = 1'b1;
        d0 = done_total;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_xy", {x, y}, 64'd0);
        check("abort_ready", 64'(src_ready), 64'd0);
        repeat (5) step();
        check("abort_acc", 64'(mon_acc), 64'd6);
        check("abort_no_done", 64'(done_total - d0), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_xy", {x, y}, 64'd0);
        wait_done(1'b0, 100);
        check_frame("restart");
        repeat (2) step();

        // reset during flush cycle 5
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("in_flush", 64'(pipe_flush), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstf_pipe_valid", 64'(pipe_valid), 64'd0);
        check("rstf_pipe_flush", 64'(pipe_flush), 64'd0);
        check("rstf_busy", 64'(busy), 64'd0);
        d0 = done_total;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        check("rstf_no_done", 64'(done_total - d0), 64'd0);
        check("rstf_in_beats", 64'(in_beats), 64'd0);

        // start ignored in RUN, FLUSH and DONE
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        check("ign_in_flush", 64'(pipe_flush), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("ign_in_done", 64'(frame_done), 64'd1);
        start = 1'b1;
        step();
        check("ign_done_start", 64'(busy), 64'd0);
        step();
        start = 1'b0;
        check("idle_start_busy", 64'(busy), 64'd1);
        check("idle_start_ready", 64'(src_ready), 64'd1);
        wait_done(1'b0, 100);
        check_frame("second");
        src_valid = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_frame_ctrl.md
EDGE_FRAME_CTRL -- requirements
Module: edge_frame_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 640, frame width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 480, frame height in lines.
REQ-003 The block SHALL have parameter PPB, default 8, pixels per input beat; WIDTH SHALL be a multiple of PPB.
REQ-004 The block SHALL have parameter FLUSH_BEATS, default 3*WIDTH/PPB, the number of zero-pixel beats injected after the last frame beat to drain the line buffers; minimum 1.
REQ-005 The block SHALL have these ports:
  clk  in  1  clock; rst_n  in  1  asynchronous active-low reset
  start  in  1  begin frame (sampled in IDLE only); abort  in  1  cancel frame
  src_valid  in  1  source beat valid; src_ready  out  1  controller accepts beat
  pipe_valid  out  1  valid into pixel pipeline; pipe_flush  out  1  pipeline input forced to zero
  x  out  16  column of next beat; y  out  16  line of next beat
  sof / eol / eof  out  1 each  first / line-last / frame-last accepted beat
  sink_valid  in  1  pipeline output valid; busy  out  1  state != IDLE
  frame_done  out  1  one-cycle end-of-frame pulse
  in_beats  out  32  latched input beat count; out_beats  out  32  latched output beat count

Function
REQ-006 States SHALL be IDLE, RUN, FLUSH and DONE, encoded in a registered state variable.
REQ-007 IDLE: start=1 -> RUN next cycle with x=0 and y=0; start in any other state SHALL be ignored.
REQ-008 src_ready SHALL be 1 exactly when state=RUN (combinational from state); a beat is accepted when src_valid and src_ready are both 1.
REQ-009 On an accepted beat: x <= x+PPB; if x+PPB >= WIDTH then x <= 0 and y <= y+1.
REQ-010 sof, eol and eof SHALL be combinational and qualified by acceptance: sof = (x=0, y=0); eol = (x+PPB >= WIDTH); eof = eol and (y=HEIGHT-1).
REQ-011 An accepted beat with eof=1 SHALL move RUN -> FLUSH next cycle, with the flush counter loaded to 0.
REQ-012 pipe_valid SHALL equal beat acceptance in RUN and SHALL be 1 in every FLUSH cycle; pipe_flush SHALL be 1 only in FLUSH.
REQ-013 FLUSH SHALL last exactly FLUSH_BEATS cycles, then enter DONE.
REQ-014 DONE SHALL last one cycle with frame_done=1, then enter IDLE; frame_done SHALL be 0 in all other states.
REQ-015 When src_valid=0 in RUN, counters SHALL hold and there SHALL be no timeout.
REQ-016 abort=1 in any state SHALL force IDLE next cycle and clear x, y and the flush counter, with no frame_done pulse. abort SHALL take priority over start, eof and the FLUSH exit. A beat accepted in the abort cycle SHALL still drive pipe_valid but SHALL NOT advance x or y.
REQ-017 x and y SHALL saturate-free wrap only as in REQ-009; y SHALL never exceed HEIGHT-1 during RUN.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously force state=IDLE, x=0, y=0, flush counter=0, frame_done=0, in_beats=0 and out_beats=0.
REQ-019 Because src_ready, pipe_valid and pipe_flush are combinational from state, they SHALL read 0 during reset.
REQ-020 Reset mid-frame SHALL discard the frame; there SHALL be no frame_done pulse.

Configuration
REQ-021 The macro EDGE_FRAME_STATS_EN SHALL control the frame statistics feature.
REQ-022 With EDGE_FRAME_STATS_EN defined:
- internal counters SHALL clear on the IDLE->RUN transition;
- they SHALL count accepted beats and sink_valid cycles while busy=1;
- they SHALL be latched into in_beats and out_beats in the DONE cycle, and held until the next DONE or reset;
- abort SHALL NOT update the latched values.
REQ-023 Without EDGE_FRAME_STATS_EN, in_beats and out_beats SHALL be constant 0, no counter logic SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-024 Run with WIDTH=32, HEIGHT=4, PPB=8, FLUSH_BEATS=12. Pulse start, then hold src_valid=1. Required response:
- 16 beats are accepted;
- sof on beat 1;
- eol on beats 4, 8, 12 and 16;
- eof on beat 16;
- 12 cycles with pipe_flush=1;
- frame_done exactly 1 cycle after the last flush cycle;
- in_beats=16 when the macro is defined.
REQ-025 Same configuration, with src_valid toggling 1/0 every cycle: beats are still accepted only when src_valid=1, x and y hold in gap cycles, and frame_done arrives after 16 accepted beats.
REQ-026 Assert abort in the cycle of accepted beat 6: next cycle state=IDLE, x=0, y=0, busy=0, no frame_done; a following start restarts from x=0, y=0.
REQ-027 Assert rst_n=0 during FLUSH cycle 5: pipe_valid, pipe_flush and busy read 0 immediately; no frame_done; in_beats keeps 0 after reset.
REQ-028 Pulse start while in RUN and while in FLUSH: it is ignored. start asserted in the DONE cycle is ignored, and a start in the next (IDLE) cycle begins a new frame.
